// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one 1-bit full adder (adder_1) is stepped N
// times, LSB first, to add two N-bit operands. Operands are captured and
// results delivered through valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for operands, i_ready high
// ADD   | one operand bit pair summed per cycle, N cycles total
// DONE  | result presented on o_sum/o_c_out until the consumer takes it
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c_in,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] o_sum,
  output logic         o_c_out,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_sr, b_sr, res_sr;
  logic [N-1:0]  a_shr, b_shr, res_shr;
  logic [N-1:0]  sum_hold;
  logic          carry, c_hold;
  logic [CW-1:0] count;
  logic          add_s, add_co;

  // adder_1: the single shared full adder
  assign add_s  = a_sr[0] ^ b_sr[0] ^ carry;
  assign add_co = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  // Right-shifted views of the operand and result registers; the sum bit
  // enters at the result MSB so the result is LSB-aligned after N shifts.
  always_comb begin
    a_shr          = '0;
    b_shr          = '0;
    res_shr        = '0;
    res_shr[N-1]   = add_s;
    for (int i = 0; i < N - 1; i++) begin
      a_shr[i]   = a_sr[i+1];
      b_shr[i]   = b_sr[i+1];
      res_shr[i] = res_sr[i+1];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)        state_nxt = ADD;
      ADD:     if (count == LAST)  state_nxt = DONE;
      DONE:    if (o_ready)        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial add steps, and result hold on handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum_hold <= '0;
      c_hold   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a_sr  <= i_a;
          b_sr  <= i_b;
          carry <= i_c_in;
          count <= '0;
        end
        ADD: begin
          a_sr   <= a_shr;
          b_sr   <= b_shr;
          res_sr <= res_shr;
          carry  <= add_co;
          count  <= count + 1'b1;
        end
        DONE: if (o_ready) begin
          sum_hold <= res_sr;
          c_hold   <= carry;
        end
        default: ;
      endcase
    end
  end

  // In DONE the live result is shown; otherwise the last delivered result
  // stays visible, which keeps o_sum stable while ADD reuses res_sr.
  assign o_sum   = (state == DONE) ? res_sr : sum_hold;
  assign o_c_out = (state == DONE) ? carry  : c_hold;
  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign busy    = (state != IDLE);

endmodule
